// File: rtl/tlight_junction_if.sv
// Request inputs and lamp outputs of the junction controller.
// The controller takes the slave modport; whatever drives the buttons takes the master modport.
interface tlight_junction_if #(
    parameter int NUM_DIR = 2
);
    localparam int PW = ($clog2(NUM_DIR) > 1) ? $clog2(NUM_DIR) : 1;

    logic               ped_req;
    logic               flash_en;
    logic [NUM_DIR-1:0] r;
    logic [NUM_DIR-1:0] a;
    logic [NUM_DIR-1:0] g;
    logic               walk;
    logic               ped_wait;
    logic [PW-1:0]      phase;

    modport master (
        output ped_req, flash_en,
        input  r, a, g, walk, ped_wait, phase
    );

    modport slave (
        input  ped_req, flash_en,
        output r, a, g, walk, ped_wait, phase
    );
endinterface

// File: rtl/tlight_junction.sv
// Round-robin multi-head traffic-light controller with a latched pedestrian walk phase
// and an amber-flash service mode; lamps are Moore decodes of state, phase and flash_bit.
//
// state       | meaning
// ALL_RED     | clearance, every head red
// RED_AMBER   | head `phase` shows red+amber
// GREEN       | head `phase` shows green
// AMBER       | head `phase` shows amber
// PED_WALK    | every head red, walk lamp on
// FLASH       | service mode, all ambers blink together
module tlight_junction #(
    parameter int NUM_DIR       = 2,
    parameter int TIMER_W       = 8,
    parameter int ALL_RED_CYC   = 2,
    parameter int RED_AMBER_CYC = 2,
    parameter int GREEN_CYC     = 8,
    parameter int AMBER_CYC     = 3,
    parameter int WALK_CYC      = 6,
    parameter int FLASH_CYC     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    tlight_junction_if.slave  bus
);
    localparam int PW = ($clog2(NUM_DIR) > 1) ? $clog2(NUM_DIR) : 1;

    localparam logic [TIMER_W-1:0] T_ALL_RED   = TIMER_W'(ALL_RED_CYC - 1);
    localparam logic [TIMER_W-1:0] T_RED_AMBER = TIMER_W'(RED_AMBER_CYC - 1);
    localparam logic [TIMER_W-1:0] T_GREEN     = TIMER_W'(GREEN_CYC - 1);
    localparam logic [TIMER_W-1:0] T_AMBER     = TIMER_W'(AMBER_CYC - 1);
    localparam logic [TIMER_W-1:0] T_WALK      = TIMER_W'(WALK_CYC - 1);
    localparam logic [TIMER_W-1:0] T_FLASH     = TIMER_W'(FLASH_CYC - 1);
    localparam logic [PW-1:0]      LAST_DIR    = PW'(NUM_DIR - 1);

    typedef enum logic [2:0] {
        S_ALL_RED,
        S_RED_AMBER,
        S_GREEN,
        S_AMBER,
        S_PED_WALK,
        S_FLASH
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      phase_q, phase_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               ped_pend_q, ped_pend_d;
    logic               flash_bit_q, flash_bit_d;
    logic               timer_done;
    logic [NUM_DIR-1:0] dir_oh;

    assign timer_done = (timer_q == '0);
    assign dir_oh     = NUM_DIR'(1) << phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ALL_RED;
            phase_q     <= '0;
            timer_q     <= T_ALL_RED;
            ped_pend_q  <= 1'b0;
            flash_bit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            timer_q     <= timer_d;
            ped_pend_q  <= ped_pend_d;
            flash_bit_q <= flash_bit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        timer_d     = timer_q - TIMER_W'(1);
        flash_bit_d = flash_bit_q;

        if (bus.flash_en) begin
            if (state_q != S_FLASH) begin
                state_d     = S_FLASH;
                timer_d     = T_FLASH;
                flash_bit_d = 1'b1;
            end else if (timer_done) begin
                timer_d     = T_FLASH;
                flash_bit_d = ~flash_bit_q;
            end
        end else begin
            unique case (state_q)
                S_ALL_RED: if (timer_done) begin
                    state_d = S_RED_AMBER;
                    timer_d = T_RED_AMBER;
                end
                S_RED_AMBER: if (timer_done) begin
                    state_d = S_GREEN;
                    timer_d = T_GREEN;
                end
                S_GREEN: if (timer_done) begin
                    state_d = S_AMBER;
                    timer_d = T_AMBER;
                end
                S_AMBER: if (timer_done) begin
                    if (phase_q == LAST_DIR && ped_pend_q) begin
                        state_d = S_PED_WALK;
                        timer_d = T_WALK;
                    end else begin
                        state_d = S_ALL_RED;
                        timer_d = T_ALL_RED;
                    end
                    phase_d = (phase_q == LAST_DIR) ? '0 : phase_q + PW'(1);
                end
                S_PED_WALK: if (timer_done) begin
                    state_d = S_ALL_RED;
                    timer_d = T_ALL_RED;
                    phase_d = '0;
                end
                S_FLASH: begin
                    state_d     = S_ALL_RED;
                    timer_d     = T_ALL_RED;
                    phase_d     = '0;
                    flash_bit_d = 1'b0;
                end
                default: begin
                    state_d = S_ALL_RED;
                    timer_d = T_ALL_RED;
                    phase_d = '0;
                end
            endcase
        end
    end

    // Entering the walk clears the request even if the button is pressed on that same edge.
    always_comb begin
        ped_pend_d = ped_pend_q;
        if (state_d == S_PED_WALK && state_q != S_PED_WALK) begin
            ped_pend_d = 1'b0;
        end else if (state_q != S_PED_WALK && bus.ped_req) begin
            ped_pend_d = 1'b1;
        end
    end

    always_comb begin
        bus.r        = '1;
        bus.a        = '0;
        bus.g        = '0;
        bus.walk     = 1'b0;
        bus.ped_wait = ped_pend_q;
        bus.phase    = phase_q;
        unique case (state_q)
            S_ALL_RED:   ;
            S_RED_AMBER: bus.a = dir_oh;
            S_GREEN: begin
                bus.r = ~dir_oh;
                bus.g = dir_oh;
            end
            S_AMBER: begin
                bus.r = ~dir_oh;
                bus.a = dir_oh;
            end
            S_PED_WALK:  bus.walk = 1'b1;
            S_FLASH: begin
                bus.r = '0;
                bus.a = {NUM_DIR{flash_bit_q}};
            end
            default:     ;
        endcase
    end
endmodule

// File: tb/tb_tlight_junction.sv
// Directed and randomised checks of tlight_junction with a two-head, short-dwell configuration.
module tb_tlight_junction;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    tlight_junction_if #(.NUM_DIR(2)) bus ();

    tlight_junction #(
        .NUM_DIR(2), .TIMER_W(8), .ALL_RED_CYC(1), .RED_AMBER_CYC(2),
        .GREEN_CYC(4), .AMBER_CYC(2), .WALK_CYC(3), .FLASH_CYC(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ped_req;
        logic       flash_en;
        logic [1:0] r;
        logic [1:0] a;
        logic [1:0] g;
        logic       walk;
        logic       ped_wait;
        logic       phase;
    } vec_t;

    // One 18-cycle period of the free-running sequence, cycle 0 = first cycle after reset.
    logic [1:0] pat_r [18] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                               2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    logic [1:0] pat_a [18] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01,
                               2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10};
    logic [1:0] pat_g [18] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00,
                               2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};

    vec_t vecs [40];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // epw / eph < 0 means "don't care" for ped_wait / phase.
    task automatic chk(input string name, input logic [1:0] er, input logic [1:0] ea,
                       input logic [1:0] eg, input logic ew, input int epw, input int eph);
        logic ok;
        checks++;
        ok = (bus.r === er) && (bus.a === ea) && (bus.g === eg) && (bus.walk === ew);
        if (epw >= 0 && bus.ped_wait !== epw[0]) ok = 1'b0;
        if (eph >= 0 && bus.phase !== eph[0]) ok = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got r=%b a=%b g=%b walk=%b ped_wait=%b phase=%0d, want r=%b a=%b g=%b walk=%b ped_wait=%0d phase=%0d",
                     name, bus.r, bus.a, bus.g, bus.walk, bus.ped_wait, bus.phase,
                     er, ea, eg, ew, epw, eph);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.ped_req = 1'b0;
        bus.flash_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 2'b11, 2'b00, 2'b00, 1'b0, 0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.ped_req = 1'b0;
        bus.flash_en = 1'b0;

        for (int i = 0; i < 40; i++) begin
            vecs[i].ped_req  = 1'b0;
            vecs[i].flash_en = 1'b0;
            vecs[i].r        = pat_r[i % 18];
            vecs[i].a        = pat_a[i % 18];
            vecs[i].g        = pat_g[i % 18];
            vecs[i].walk     = 1'b0;
            vecs[i].ped_wait = 1'b0;
            vecs[i].phase    = ((i % 18) >= 9) ? 1'b1 : 1'b0;
        end

        // Free-run table
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (i > 0) step();
            chk($sformatf("freerun[%0d]", i), vecs[i].r, vecs[i].a, vecs[i].g,
                vecs[i].walk, int'(vecs[i].ped_wait), int'(vecs[i].phase));
            bus.ped_req  = vecs[i].ped_req;
            bus.flash_en = vecs[i].flash_en;
        end

        // One-cycle pedestrian request during direction 0 green
        do_reset();
        repeat (3) step();
        chk("ped_green0", 2'b10, 2'b00, 2'b01, 1'b0, 0, 0);
        bus.ped_req = 1'b1;
        step();
        bus.ped_req = 1'b0;
        chk("ped_latched", 2'b10, 2'b00, 2'b01, 1'b0, 1, 0);
        repeat (13) step();
        chk("ped_amber1", 2'b01, 2'b10, 2'b00, 1'b0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("ped_walk[%0d]", k), 2'b11, 2'b00, 2'b00, 1'b1, 0, 0);
        end
        step();
        chk("ped_after_allred", 2'b11, 2'b00, 2'b00, 1'b0, 0, 0);
        step();
        chk("ped_after_redamber", 2'b11, 2'b01, 2'b00, 1'b0, 0, 0);

        // Request held high through the walk
        do_reset();
        repeat (3) step();
        bus.ped_req = 1'b1;
        step();
        chk("hold_latched", 2'b10, 2'b00, 2'b01, 1'b0, 1, 0);
        repeat (13) step();
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("hold_walk[%0d]", k), 2'b11, 2'b00, 2'b00, 1'b1, 0, 0);
        end
        step();
        chk("hold_allred", 2'b11, 2'b00, 2'b00, 1'b0, -1, 0);
        step();
        chk("hold_relatched", 2'b11, 2'b01, 2'b00, 1'b0, 1, 0);
        bus.ped_req = 1'b0;

        // Flash mode entered during direction 1 green
        do_reset();
        repeat (12) step();
        chk("flash_pre_green1", 2'b01, 2'b00, 2'b10, 1'b0, 0, 1);
        bus.flash_en = 1'b1;
        step(); chk("flash[0]", 2'b00, 2'b11, 2'b00, 1'b0, 0, -1);
        step(); chk("flash[1]", 2'b00, 2'b11, 2'b00, 1'b0, 0, -1);
        step(); chk("flash[2]", 2'b00, 2'b00, 2'b00, 1'b0, 0, -1);
        step(); chk("flash[3]", 2'b00, 2'b00, 2'b00, 1'b0, 0, -1);
        step(); chk("flash[4]", 2'b00, 2'b11, 2'b00, 1'b0, 0, -1);
        bus.flash_en = 1'b0;
        step(); chk("flash_exit_allred", 2'b11, 2'b00, 2'b00, 1'b0, 0, 0);
        step(); chk("flash_exit_redamber", 2'b11, 2'b01, 2'b00, 1'b0, 0, 0);

        // Asynchronous reset in the middle of an amber with a request pending
        do_reset();
        repeat (3) step();
        bus.ped_req = 1'b1;
        step();
        bus.ped_req = 1'b0;
        repeat (3) step();
        chk("mid_amber", 2'b10, 2'b01, 2'b00, 1'b0, 1, 0);
        #1 rst_n = 1'b0;
        #1 chk("async_reset", 2'b11, 2'b00, 2'b00, 1'b0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post_reset_allred", 2'b11, 2'b00, 2'b00, 1'b0, 0, 0);
        step();
        chk("post_reset_redamber", 2'b11, 2'b01, 2'b00, 1'b0, 0, 0);

        // Random requests and flash, safety invariants every cycle
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            bus.ped_req = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) bus.flash_en = ~bus.flash_en;
            step();
            checks++;
            if (!$onehot0(bus.g) || ((bus.g & bus.r) != 2'b00) ||
                (bus.walk && (bus.g != 2'b00 || bus.r != 2'b11))) begin
                errors++;
                $display("FAIL invariant cycle %0d: got r=%b a=%b g=%b walk=%b, want single green, no red+green, walk only with all red",
                         i, bus.r, bus.a, bus.g, bus.walk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
